// File: rtl/sad_stream_engine.sv
// Streaming SAD engine: DEPTH-word reference window vs NUM_CH candidate rows, per-beat SAD and
// running minimum per channel. Optional macro SAD_STREAM_THRESH_EN adds a sticky threshold early exit.
module sad_stream_engine #(
    parameter int LANES  = 4,
    parameter int DEPTH  = 4,
    parameter int NUM_CH = 2,
    parameter int ACC_W  = 16,
    parameter int IDX_W  = 16
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      start,
    input  logic                      win_valid,
    output logic                      win_ready,
    input  logic [8*LANES-1:0]        win_data,
    input  logic                      frm_valid,
    output logic                      frm_ready,
    input  logic                      frm_last,
    input  logic [NUM_CH*8*LANES-1:0] frm_data,
    output logic                      busy,
    output logic                      sad_valid,
    output logic [NUM_CH*ACC_W-1:0]   sad_out,
    output logic [IDX_W-1:0]          sad_idx,
    output logic                      done,
    output logic [NUM_CH*ACC_W-1:0]   min_sad,
`ifdef SAD_STREAM_THRESH_EN
    input  logic [ACC_W-1:0]          thresh,
    output logic [NUM_CH-1:0]         thresh_hit,
`endif
    output logic [NUM_CH*IDX_W-1:0]   min_idx
);
    localparam int W     = 8 * LANES;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int SUM_W = 9 + $clog2(DEPTH * LANES);
    localparam int T_W   = ((SUM_W > ACC_W) ? SUM_W : ACC_W) + 1;
    localparam logic [T_W-1:0] SAT_MAX  = T_W'({ACC_W{1'b1}});
    localparam logic [CW-1:0]  LAST_POS = CW'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [W-1:0]     r_win     [DEPTH];
    logic [W-1:0]     r_hist    [NUM_CH][DEPTH];
    logic [W-1:0]     w_cand    [NUM_CH][DEPTH];
    logic [ACC_W-1:0] w_sad     [NUM_CH];
    logic [ACC_W-1:0] r_sad     [NUM_CH];
    logic [ACC_W-1:0] r_min     [NUM_CH];
    logic [IDX_W-1:0] r_min_idx [NUM_CH];
    logic [CW-1:0]    r_wcnt;
    logic [CW-1:0]    r_fill;
    logic [IDX_W-1:0] r_beat;
    logic [IDX_W-1:0] r_sad_idx;
    logic             r_sad_valid;
    logic             w_win_acc;
    logic             w_accept;
    logic             w_run_entry;
    logic             w_all_hit;

    always_ff @(posedge Clk) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        win_ready = 1'b0;
        frm_ready = 1'b0;
        done      = 1'b0;
        busy      = (r_state != S_IDLE);
        case (r_state)
            S_IDLE:  if (start) w_next = S_LOAD;
            S_LOAD: begin
                win_ready = 1'b1;
                if (win_valid && (r_wcnt == LAST_POS)) w_next = S_RUN;
            end
            S_RUN: begin
                if (w_all_hit) begin
                    w_next = S_FLUSH;
                end else begin
                    frm_ready = 1'b1;
                    if (frm_valid && frm_last) w_next = S_FLUSH;
                end
            end
            S_FLUSH: w_next = S_DONE;
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_win_acc   = win_ready & win_valid;
    assign w_accept    = frm_ready & frm_valid;
    assign w_run_entry = (r_state == S_LOAD) && (w_next == S_RUN);

    // Candidate history as it will be after this beat: slot 0 is the incoming word.
    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            w_cand[c][0] = frm_data[c*W +: W];
            for (int unsigned k = 1; k < DEPTH; k++) w_cand[c][k] = r_hist[c][k-1];
        end
    end

    always_comb begin
        logic [T_W-1:0] acc;
        logic [7:0]     a;
        logic [7:0]     b;
        acc = '0;
        a   = '0;
        b   = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            acc = '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                for (int unsigned l = 0; l < LANES; l++) begin
                    a   = r_win[k][l*8 +: 8];
                    b   = w_cand[c][k][l*8 +: 8];
                    acc = acc + T_W'((a > b) ? (a - b) : (b - a));
                end
            end
            w_sad[c] = (acc > SAT_MAX) ? '1 : acc[ACC_W-1:0];
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int unsigned k = 0; k < DEPTH; k++) r_win[k] <= '0;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                for (int unsigned k = 0; k < DEPTH; k++) r_hist[c][k] <= '0;
                r_sad[c]     <= '0;
                r_min[c]     <= '1;
                r_min_idx[c] <= '0;
            end
            r_wcnt      <= '0;
            r_fill      <= '0;
            r_beat      <= '0;
            r_sad_idx   <= '0;
            r_sad_valid <= 1'b0;
        end else begin
            r_sad_valid <= 1'b0;
            if (w_win_acc) begin
                for (int unsigned k = 0; k + 1 < DEPTH; k++) r_win[k] <= r_win[k+1];
                r_win[DEPTH-1] <= win_data;
                r_wcnt         <= r_wcnt + CW'(1);
            end
            if (r_sad_valid) begin
                for (int unsigned c = 0; c < NUM_CH; c++) begin
                    if (r_sad[c] < r_min[c]) begin
                        r_min[c]     <= r_sad[c];
                        r_min_idx[c] <= r_sad_idx;
                    end
                end
            end
            if (w_run_entry) begin
                r_wcnt <= '0;
                r_fill <= '0;
                r_beat <= '0;
                for (int unsigned c = 0; c < NUM_CH; c++) begin
                    for (int unsigned k = 0; k < DEPTH; k++) r_hist[c][k] <= '0;
                    r_min[c]     <= '1;
                    r_min_idx[c] <= '0;
                end
            end else if (w_accept) begin
                for (int unsigned c = 0; c < NUM_CH; c++) begin
                    for (int unsigned k = 0; k < DEPTH; k++) r_hist[c][k] <= w_cand[c][k];
                    r_sad[c] <= w_sad[c];
                end
                r_sad_valid <= (r_fill == LAST_POS);
                r_sad_idx   <= r_beat;
                if (r_fill != LAST_POS) r_fill <= r_fill + CW'(1);
                if (r_beat != '1)       r_beat <= r_beat + IDX_W'(1);
            end
        end
    end

`ifdef SAD_STREAM_THRESH_EN
    logic [NUM_CH-1:0] r_hit;

    always_ff @(posedge Clk) begin
        if (Reset || w_run_entry) begin
            r_hit <= '0;
        end else if (r_sad_valid) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (r_sad[c] <= thresh) r_hit[c] <= 1'b1;
            end
        end
    end

    assign w_all_hit  = &r_hit;
    assign thresh_hit = r_hit;
`else
    assign w_all_hit = 1'b0;
`endif

    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            sad_out[c*ACC_W +: ACC_W] = r_sad[c];
            min_sad[c*ACC_W +: ACC_W] = r_min[c];
            min_idx[c*IDX_W +: IDX_W] = r_min_idx[c];
        end
    end

    assign sad_valid = r_sad_valid;
    assign sad_idx   = r_sad_idx;

endmodule

// File: doc/sad_stream_engine.md
Name: sad_stream_engine

Overview:
- Parametrised successor to the fixed two-channel, four-word SAD unit.
- Holds a DEPTH-word reference window and streams NUM_CH candidate frame rows past it, one word per channel per beat.
- On every beat it produces the registered full-window SAD per channel at word-granular alignment.
- Tracks the running minimum and its beat index per channel, and reports them on completion.
- Feeds the motion-search controller in place of the combinational SAD path.

Parameters:
- LANES, 4, 8-bit pixels per word (word width W = 8*LANES)
- DEPTH, 4, window length in words (alignment span)
- NUM_CH, 2, parallel candidate frame channels
- ACC_W, 16, SAD result width (saturating)
- IDX_W, 16, beat index / counter width

Ports:
- Clk  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- start  in  1  pulse; begins a pass when idle
- win_valid  in  1  window word valid
- win_ready  out  1  high in LOAD only
- win_data  in  W  window word; first accepted word = window word 0
- frm_valid  in  1  frame beat valid (all channels together)
- frm_ready  out  1  high in RUN only
- frm_last  in  1  marks final frame beat of the pass
- frm_data  in  NUM_CH*W  channel c occupies bits [c*W +: W]
- busy  out  1  high when state != IDLE
- sad_valid  out  1  sad_out valid this cycle
- sad_out  out  NUM_CH*ACC_W  per-channel SAD of the current alignment
- sad_idx  out  IDX_W  beat index of the sad_out alignment
- done  out  1  one-cycle pulse at end of pass
- min_sad  out  NUM_CH*ACC_W  per-channel minimum SAD
- min_idx  out  NUM_CH*IDX_W  beat index of each minimum

Behaviour:
- Reset: all outputs 0 except min_sad = all ones. State goes to IDLE, window/frame shift registers and counters clear. Reset mid-pass aborts with no done pulse.
- FSM states are IDLE, LOAD, RUN, FLUSH, DONE.
- IDLE -> LOAD on start. start is ignored in every other state.
- LOAD: win_ready=1. Each accepted word shifts into the window register. After DEPTH accepted words -> RUN.
- Entering RUN:
  - Frame shift registers, beat counter and fill counter clear.
  - min_sad resets to all ones and min_idx to 0.
- RUN: frm_ready=1. A beat is accepted when frm_valid=1.
  - Each accepted beat shifts the new word into each channel's DEPTH-word history; the newest word aligns with window word 0.
  - Beat index = count of previously accepted beats in this pass, starting at 0. It saturates at 2^IDX_W-1.
- An alignment is valid once at least DEPTH beats have been accepted in the pass, i.e. index >= DEPTH-1.
- SAD computation:
  - SAD = sum over all DEPTH*LANES byte pairs of |w - f|, unsigned.
  - Result saturates at 2^ACC_W-1.
- Latency: sad_valid, sad_out and sad_idx are registered 1 cycle after the accepted beat. sad_valid=0 for beats before the window is filled.
- Minimum update, per channel, on sad_valid: if sad < min_sad, update min_sad and min_idx.
  - The compare is strict less, so the earliest index wins ties.
- Accepted beat with frm_last=1 -> FLUSH for 1 cycle, where the final sad_valid appears -> DONE.
- DONE: done=1 for exactly 1 cycle, then -> IDLE.
  - min_sad and min_idx are stable from the done cycle until the next RUN entry.
- A pass that ends before DEPTH beats produces no sad_valid. done still pulses, with min_sad = all ones and min_idx = 0.
- win_valid outside LOAD and frm_valid outside RUN are ignored.
- frm_last is ignored in LOAD.
- Back-to-back passes: start may be asserted in the cycle after done.

Optional Feature:
- Macro: SAD_STREAM_THRESH_EN.
- With the macro defined:
  - Adds input thresh [ACC_W] and output thresh_hit [NUM_CH].
  - thresh_hit[c] is sticky: it sets on any sad_valid where channel c's SAD <= thresh.
  - thresh_hit clears on RUN entry and on Reset.
  - The pass ends early (-> FLUSH) in the cycle after all channels hit. Further frm_valid is not accepted.
- Without the macro: the ports are absent and a pass ends only via frm_last.

Test Plan:
- Defaults, window bytes all 0x10.
  - Stimulus: ch0 frame all 0x10, ch1 all 0x12, 6 beats, last on beat 5.
  - Required: sad_valid on indices 3..5 with ch0=0 and ch1=32; min_sad = {32, 0}; min_idx = {3, 3}; done 2 cycles after the last beat.
- Window words 0x01020304, 0x05060708, 0x090A0B0C, 0x0D0E0F10.
  - Stimulus: ch0 streams them in reverse order (word 3 first), then 0xFFFFFFFF.
  - Required: ch0 SAD = 0 at index 3, min_idx[ch0] = 3; index 4 gives a nonzero SAD and no update.
- Tie case:
  - Stimulus: ch0 frame gives equal SAD=40 at indices 3 and 7.
  - Required: min_idx = 3.
- Short pass:
  - Stimulus: frm_last on beat 1.
  - Required: no sad_valid; done pulses; min_sad = 0xFFFF.
- Reset and start handling:
  - Stimulus: Reset asserted mid-RUN at beat 4.
  - Required: next cycle busy=0 and no done. start during RUN is ignored and the pass completes normally.
- Saturation (ACC_W=8):
  - Stimulus: window 0x00, frame 0xFF.
  - Required: sad_out = 0xFF.
  - With SAD_STREAM_THRESH_EN and thresh=0: both channels exact -> thresh_hit = 2'b11 and early done.
